// File: rtl/janken_judge.sv
// Rock-paper-scissors round judge: syncs the reveal and clear inputs,
// judges three latched hands on each reveal, and keeps match scores.
//
// state | meaning
// IDLE  | waiting for a pon rising edge; hands are latched on that edge
// JUDGE | one cycle: evaluate latched hands, update results and counters
// SHOW  | results held until synchronised pon returns low
// OVER  | a player reached WIN_TARGET; only clr_ leaves this state
module janken_judge #(
    parameter int SCORE_W     = 4,
    parameter int WIN_TARGET  = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic               pon,
    input  logic               clr_,
    input  logic [5:0]         g_data_in,
    output logic [2:0]         winner,
    output logic               draw,
    output logic               invalid,
    output logic               res_valid,
    output logic [SCORE_W-1:0] score2,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score0,
    output logic [SCORE_W-1:0] draw_cnt,
    output logic               match_over,
    output logic [2:0]         champion
);

    typedef enum logic [1:0] {IDLE, JUDGE, SHOW, OVER} state_t;

    localparam logic [1:0] GU    = 2'b01;
    localparam logic [1:0] CHOKI = 2'b10;
    localparam logic [1:0] PA    = 2'b11;
    localparam logic [SCORE_W-1:0] TARGET = SCORE_W'(WIN_TARGET);

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] pon_sync;
    logic [SYNC_STAGES-1:0] clr_sync;
    logic                   pon_prev;
    logic                   pon_s;
    logic                   pon_rise;
    logic                   clr_act;
    logic                   capture;
    logic [5:0]             hand_q;

    logic [1:0]         h0, h1, h2;
    logic [2:0]         present;
    logic [1:0]         n_present;
    logic               has_gu, has_choki, has_pa;
    logic [1:0]         n_kinds;
    logic [1:0]         win_hand;
    logic               j_invalid;
    logic               j_draw;
    logic [2:0]         j_winner;
    logic [SCORE_W-1:0] nxt_score0, nxt_score1, nxt_score2;
    logic [2:0]         nxt_champ;

    assign pon_s    = pon_sync[SYNC_STAGES-1];
    assign pon_rise = pon_s & ~pon_prev;
    assign clr_act  = ~clr_sync[SYNC_STAGES-1];

    // Synchronisers for the asynchronous switches plus pon edge history.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            pon_sync <= '0;
            clr_sync <= '0;
            pon_prev <= 1'b0;
        end else begin
            pon_sync <= {pon_sync[SYNC_STAGES-2:0], pon};
            clr_sync <= {clr_sync[SYNC_STAGES-2:0], clr_};
            pon_prev <= pon_s;
        end
    end

    assign h0 = hand_q[1:0];
    assign h1 = hand_q[3:2];
    assign h2 = hand_q[5:4];

    assign present   = {h2 != 2'b00, h1 != 2'b00, h0 != 2'b00};
    assign n_present = {1'b0, present[0]} + {1'b0, present[1]} + {1'b0, present[2]};
    assign has_gu    = (h0 == GU)    | (h1 == GU)    | (h2 == GU);
    assign has_choki = (h0 == CHOKI) | (h1 == CHOKI) | (h2 == CHOKI);
    assign has_pa    = (h0 == PA)    | (h1 == PA)    | (h2 == PA);
    assign n_kinds   = {1'b0, has_gu} + {1'b0, has_choki} + {1'b0, has_pa};

    // Pick the beating hand when exactly two kinds are on the table.
    always_comb begin
        win_hand = 2'b00;
        if (has_gu && has_choki)
            win_hand = GU;
        else if (has_choki && has_pa)
            win_hand = CHOKI;
        else if (has_pa && has_gu)
            win_hand = PA;
    end

    assign j_invalid = (n_present < 2'd2);
    assign j_draw    = !j_invalid && (n_kinds != 2'd2);
    assign j_winner  = (!j_invalid && n_kinds == 2'd2)
                     ? {h2 == win_hand, h1 == win_hand, h0 == win_hand} : 3'b000;

    assign nxt_score0 = score0 + SCORE_W'(j_winner[0]);
    assign nxt_score1 = score1 + SCORE_W'(j_winner[1]);
    assign nxt_score2 = score2 + SCORE_W'(j_winner[2]);
    assign nxt_champ  = {nxt_score2 == TARGET, nxt_score1 == TARGET, nxt_score0 == TARGET};

    // State register.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; a clear overrides everything, including a pending pon edge.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (pon_rise) begin
                    state_nxt = JUDGE;
                    capture   = 1'b1;
                end
            end
            JUDGE:   state_nxt = (|nxt_champ) ? OVER : SHOW;
            SHOW:    if (!pon_s) state_nxt = IDLE;
            OVER:    state_nxt = OVER;
            default: state_nxt = IDLE;
        endcase
        if (clr_act) begin
            state_nxt = IDLE;
            capture   = 1'b0;
        end
    end

    // Hand latch, result registers and match counters.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            hand_q     <= '0;
            winner     <= '0;
            draw       <= 1'b0;
            invalid    <= 1'b0;
            res_valid  <= 1'b0;
            score0     <= '0;
            score1     <= '0;
            score2     <= '0;
            draw_cnt   <= '0;
            match_over <= 1'b0;
            champion   <= '0;
        end else begin
            res_valid <= 1'b0;
            if (clr_act) begin
                winner     <= '0;
                draw       <= 1'b0;
                invalid    <= 1'b0;
                score0     <= '0;
                score1     <= '0;
                score2     <= '0;
                draw_cnt   <= '0;
                match_over <= 1'b0;
                champion   <= '0;
            end else if (capture) begin
                hand_q <= g_data_in;
            end else if (state == JUDGE) begin
                winner    <= j_winner;
                draw      <= j_draw;
                invalid   <= j_invalid;
                res_valid <= 1'b1;
                score0    <= nxt_score0;
                score1    <= nxt_score1;
                score2    <= nxt_score2;
                if (j_draw && draw_cnt != '1)
                    draw_cnt <= draw_cnt + SCORE_W'(1);
                if (|nxt_champ) begin
                    match_over <= 1'b1;
                    champion   <= nxt_champ;
                end
            end
        end
    end

endmodule

// File: tb/tb_janken_judge.sv
// Randomised and directed checks of janken_judge against a rule-level model.
module tb_janken_judge;

    localparam int SCORE_W    = 4;
    localparam int WIN_TARGET = 3;

    logic               clk = 1'b0;
    logic               rst_;
    logic               pon;
    logic               clr_;
    logic [5:0]         g_data_in;
    logic [2:0]         winner;
    logic               draw;
    logic               invalid;
    logic               res_valid;
    logic [SCORE_W-1:0] score2, score1, score0;
    logic [SCORE_W-1:0] draw_cnt;
    logic               match_over;
    logic [2:0]         champion;

    int n_chk  = 0;
    int n_pass = 0;

    int       m_score [3];
    int       m_draw;
    bit       m_over;
    logic [2:0] m_win;
    bit       m_dr;
    bit       m_inv;

    janken_judge #(.SCORE_W(SCORE_W), .WIN_TARGET(WIN_TARGET), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_(rst_), .pon(pon), .clr_(clr_), .g_data_in(g_data_in),
        .winner(winner), .draw(draw), .invalid(invalid), .res_valid(res_valid),
        .score2(score2), .score1(score1), .score0(score0), .draw_cnt(draw_cnt),
        .match_over(match_over), .champion(champion)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    endtask

    // Rock=1, scissors=2, paper=3: a beats b when b is one step ahead of a mod 3.
    function automatic bit beats(input int a, input int b);
        return ((b - a + 3) % 3) == 1;
    endfunction

    task automatic model_judge(input logic [5:0] h, output logic [2:0] w,
                               output bit d, output bit inv);
        int hv [3];
        int np;
        np = 0;
        for (int i = 0; i < 3; i++) begin
            hv[i] = int'(h[2*i +: 2]);
            if (hv[i] != 0) np++;
        end
        w = 3'b000; d = 1'b0; inv = 1'b0;
        if (np < 2) begin
            inv = 1'b1;
        end else begin
            for (int i = 0; i < 3; i++) begin
                bit beat_some, beaten;
                beat_some = 1'b0; beaten = 1'b0;
                if (hv[i] != 0) begin
                    for (int j = 0; j < 3; j++) begin
                        if (hv[j] != 0) begin
                            if (beats(hv[i], hv[j])) beat_some = 1'b1;
                            if (beats(hv[j], hv[i])) beaten = 1'b1;
                        end
                    end
                end
                w[i] = beat_some && !beaten;
            end
            d = (w == 3'b000);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 3; i++) m_score[i] = 0;
        m_draw = 0; m_over = 1'b0;
        m_win = 3'b000; m_dr = 1'b0; m_inv = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        logic [2:0] champ;
        for (int i = 0; i < 3; i++) champ[i] = (m_score[i] == WIN_TARGET);
        chk({tag, ".winner"},   32'(winner),     32'(m_win));
        chk({tag, ".draw"},     32'(draw),       32'(m_dr));
        chk({tag, ".invalid"},  32'(invalid),    32'(m_inv));
        chk({tag, ".score0"},   32'(score0),     32'(m_score[0]));
        chk({tag, ".score1"},   32'(score1),     32'(m_score[1]));
        chk({tag, ".score2"},   32'(score2),     32'(m_score[2]));
        chk({tag, ".draw_cnt"}, 32'(draw_cnt),   32'(m_draw));
        chk({tag, ".over"},     32'(match_over), 32'(m_over));
        chk({tag, ".champion"}, 32'(champion),   32'(m_over ? champ : 3'b000));
    endtask

    // Called just after a negedge with pon low and the judge idle.
    task automatic run_round(input logic [5:0] h, input int hold, input string tag);
        int  seen, first;
        bit  expect_res;
        logic [2:0] w;
        bit d, inv;
        expect_res = !m_over;
        g_data_in = h;
        pon = 1'b1;
        seen = 0; first = 0;
        for (int c = 1; c <= hold; c++) begin
            @(negedge clk);
            if (c == 3) g_data_in = 6'($urandom);
            if (res_valid) begin
                seen++;
                if (first == 0) first = c;
            end
        end
        if (expect_res) begin
            model_judge(h, w, d, inv);
            m_win = w; m_dr = d; m_inv = inv;
            for (int i = 0; i < 3; i++) m_score[i] += int'(w[i]);
            if (d && m_draw < (1 << SCORE_W) - 1) m_draw++;
            for (int i = 0; i < 3; i++) if (m_score[i] == WIN_TARGET) m_over = 1'b1;
            chk({tag, ".pulses"},  seen,  1);
            chk({tag, ".latency"}, first, 4);
        end else begin
            chk({tag, ".no_res"}, seen, 0);
        end
        check_outputs(tag);
        pon = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic do_clear(input string tag);
        clr_ = 1'b0;
        repeat (4) @(negedge clk);
        clr_ = 1'b1;
        repeat (4) @(negedge clk);
        model_clear();
        check_outputs(tag);
    endtask

    initial begin
        int seen;
        rst_ = 1'b0; pon = 1'b0; clr_ = 1'b1; g_data_in = 6'b0;
        model_clear();
        repeat (3) @(negedge clk);
        check_outputs("reset");
        chk("reset.res_valid", 32'(res_valid), 0);
        rst_ = 1'b1;
        repeat (4) @(negedge clk);

        run_round(6'b01_10_10, 8, "p2_gu");
        run_round(6'b01_10_11, 8, "three_kinds");
        run_round(6'b11_11_00, 8, "same_kind");
        run_round(6'b00_00_10, 50, "lone_hold50");

        do_clear("clear1");
        for (int r = 0; r < 3; r++) run_round(6'b10_11_11, 8, "p2_choki");
        chk("over.flag", 32'(match_over), 1);
        chk("over.champ", 32'(champion), 32'(3'b100));
        run_round(6'b01_10_10, 8, "over_ignored");
        do_clear("clear_over");

        // Clear and reveal land in the same synchronised cycle.
        clr_ = 1'b0; pon = 1'b1; g_data_in = 6'b01_10_10;
        seen = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 4) clr_ = 1'b1;
            if (res_valid) seen++;
        end
        chk("clr_pon.no_res", seen, 0);
        model_clear();
        check_outputs("clr_pon");
        pon = 1'b0;
        repeat (6) @(negedge clk);
        run_round(6'b10_01_01, 8, "after_clr_pon");

        // Reach OVER, then reset asynchronously between clock edges.
        for (int r = 0; r < 3; r++) run_round(6'b01_01_10, 8, "to_over");
        chk("pre_rst.over", 32'(match_over), 1);
        #2 rst_ = 1'b0;
        #1;
        model_clear();
        check_outputs("async_rst");
        @(negedge clk);
        rst_ = 1'b1;
        repeat (4) @(negedge clk);
        run_round(6'b11_01_00, 8, "after_rst");

        for (int r = 0; r < 40; r++) begin
            if (m_over) begin
                run_round(6'($urandom), 8, "rnd_over");
                do_clear("rnd_clear");
            end else begin
                run_round(6'($urandom), 8, "rnd");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/janken_judge.md
Name: janken_judge

Overview:
Downstream consumer of the hand-selector stage in the gyanken (rock-paper-scissors) design. It takes the 6-bit packed hands of three players and the reveal switch (pon), and judges each round when pon rises. It keeps per-player win scores and a draw count, and declares a match champion once a player reaches WIN_TARGET wins. Its outputs drive the LED and 7-segment result display.

Parameters:
SCORE_W, 4, width of each per-player score and of the draw counter.
WIN_TARGET, 3, wins needed to end a match; must be ≤ 2^SCORE_W-1.
SYNC_STAGES, 2, flip-flop depth of the synchronisers on pon and clr_.

Ports:
clk  input  1  system clock.
rst_  input  1  asynchronous active-low reset.
pon  input  1  reveal switch (level, asynchronous to clk); a rising edge starts a round.
clr_  input  1  match-clear push button (active-low, asynchronous to clk).
g_data_in  input  6  packed hands: [5:4]=player2, [3:2]=player1, [1:0]=player0.
winner  output  3  winner mask; bit n = player n won the last round.
draw  output  1  last judged round was a draw (aiko).
invalid  output  1  last round had fewer than 2 present players.
res_valid  output  1  one-cycle pulse when winner, draw and invalid update.
score2, score1, score0  output  SCORE_W each  per-player win counts.
draw_cnt  output  SCORE_W  count of draws; saturates at all-ones.
match_over  output  1  a player has reached WIN_TARGET.
champion  output  3  mask of players whose score equals WIN_TARGET.

Behaviour:
- Reset is asynchronous and active-low on rst_; the block is clocked on the rising edge of clk.
- While rst_=0: all outputs are 0, the state is IDLE, and the synchronisers and edge-detect registers are cleared.
- Hand encoding: 00 = absent, 01 = gu (rock), 10 = choki (scissors), 11 = pa (paper).
- Beat rules: gu beats choki, choki beats pa, pa beats gu.
- Synchronisation and edge detection:
  - pon and clr_ each pass through a SYNC_STAGES flip-flop chain.
  - A pon rising edge is detected as sync=1 while the previous sync value was 0.
  - clr_ acts on its synchronised level being 0.
- States: IDLE, JUDGE, SHOW, OVER.
- IDLE:
  - On a pon rising edge, latch g_data_in into an internal hand register and go to JUDGE.
  - Any other pon activity is ignored.
- JUDGE (exactly one cycle), evaluated on the latched hands only:
  - Fewer than 2 present players: invalid=1, winner=000, draw=0, no counter changes.
  - Present hands form 1 distinct value, or all 3 values: draw=1, winner=000, invalid=0, draw_cnt increments (saturating).
  - Exactly 2 distinct values: winner = players holding the beating hand, draw=0, invalid=0. Each winner's score increments by 1.
  - res_valid is asserted for exactly one cycle, coincident with the output update.
  - Next state is OVER if any updated score equals WIN_TARGET, otherwise SHOW.
- SHOW:
  - Results are held.
  - Return to IDLE when synchronised pon=0.
  - A pon re-rise requires a fall first, so a held pon cannot retrigger.
- OVER:
  - match_over=1 and champion is set; several players can be champion simultaneously.
  - pon is ignored; the state is left only via clr_.
- clr_ low (any state):
  - Next cycle: scores, draw_cnt, winner, draw, invalid, match_over and champion are cleared; the state goes to IDLE.
  - clr_ takes priority over a simultaneous pon edge; that edge is discarded.
  - If pon is still high after the clear, no round starts until pon falls and rises again.
- Latency: with pon first sampled high at edge k, the edge is detected after edge k+SYNC_STAGES. The hands are captured at that edge, and the results plus res_valid are visible after the following edge (k+3 for the default depth).
- g_data_in changes after the capture do not affect the round in progress.
- Scores never exceed WIN_TARGET, because the match halts in OVER.

Test Plan:
- Reset mid-OVER: pulse rst_ low asynchronously -> all outputs 0 before the next clk edge, state IDLE.
- g_data_in=6'b01_10_10, pon rises -> winner=100, score2=1, draw=0, res_valid high for one cycle, 3 clocks after pon is sampled high.
- g_data_in=6'b01_10_11 (all three hands) -> draw=1, draw_cnt=1, winner=000. Then 6'b11_11_00 -> draw=1, draw_cnt=2.
- g_data_in=6'b00_00_10 -> invalid=1, all counters unchanged. Holding pon high for 50 cycles -> exactly one res_valid pulse.
- Three rounds of 6'b10_11_11 -> score2=3, match_over=1, champion=100. A further pon rise -> no res_valid. Then clr_ low -> all cleared, state IDLE.
- clr_ falls in the same synchronised cycle as a pon rising edge -> no res_valid, scores 0. Dropping pon and raising it again -> a normal round runs.
